sync_fifo_fwft_36x512: RTL and testbench



---
 rtl/sync_fifo_fwft_36x512_pkg.sv | 9 +
 rtl/fifo_ram_36x512.sv | 21 ++
 rtl/sync_fifo_fwft_36x512.sv | 58 +++++
 tb/tb_sync_fifo_fwft_36x512.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sync_fifo_fwft_36x512_pkg.sv
// Shared sizing for the write-burst FIFO and the memory-burst reader that drains it.
package sync_fifo_fwft_36x512_pkg;
    localparam int DSIZE        = 36;
    localparam int DEPTH        = 512;
    localparam int AW           = 9;
    localparam int AFULL_THRESH = 508;
    // The reader waits until rnum covers this many words before it starts a burst.
    localparam int MEM_WR_BL    = 64;
endpackage

// File: rtl/fifo_ram_36x512.sv
// Simple dual-port storage for the FIFO.
// The read is asynchronous so the head word is on rdata in the same cycle as raddr.
module fifo_ram_36x512 #(
    parameter int DW = 36,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft_36x512.sv
// Single-clock first-word-fall-through FIFO with occupancy count and full/almost-full/empty flags.
// Pointers and count live here; storage is the asynchronous-read RAM below.
module sync_fifo_fwft_36x512 #(
    parameter int DSIZE        = sync_fifo_fwft_36x512_pkg::DSIZE,
    parameter int DEPTH        = sync_fifo_fwft_36x512_pkg::DEPTH,
    parameter int AW           = sync_fifo_fwft_36x512_pkg::AW,
    parameter int AFULL_THRESH = sync_fifo_fwft_36x512_pkg::AFULL_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DSIZE-1:0] data,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [DSIZE-1:0] q,
    output logic [AW:0]      rnum,
    output logic             empty
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          wr_acc, rd_acc;

    // A write while full is dropped even when a read frees a slot in the same cycle.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flags decode only the registered count, so no enable reaches them combinationally.
    assign rnum        = count;
    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign almost_full = (count >= (AW+1)'(AFULL_THRESH));

    fifo_ram_36x512 #(.DW(DSIZE), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data),
        .raddr (rd_ptr),
        .rdata (q)
    );
endmodule

// File: tb/tb_sync_fifo_fwft_36x512.sv
// Randomized scoreboard bench for the FWFT FIFO; a queue stands in for the FIFO contents.
module tb_sync_fifo_fwft_36x512;
    import sync_fifo_fwft_36x512_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [DSIZE-1:0] data = '0;
    logic             full, almost_full, empty;
    logic             rd_en = 1'b0;
    logic [DSIZE-1:0] q;
    logic [AW:0]      rnum;

    int checks = 0;
    int errors = 0;
    logic [DSIZE-1:0] sb [$];

    sync_fifo_fwft_36x512 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .data        (data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .q           (q),
        .rnum        (rnum),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: mid-cycle, compare DUT against the queue, then apply this cycle's enables to it.
    always @(negedge clk) begin
        int n;
        if (!rst_n) begin
            sb.delete();
            chk("rst_rnum", 64'(rnum), 0);
            chk("rst_empty", 64'(empty), 1);
            chk("rst_full", 64'(full), 0);
            chk("rst_afull", 64'(almost_full), 0);
        end else begin
            n = sb.size();
            chk("rnum", 64'(rnum), 64'(n));
            chk("empty", 64'(empty), 64'(n == 0));
            chk("full", 64'(full), 64'(n == DEPTH));
            chk("almost_full", 64'(almost_full), 64'(n >= AFULL_THRESH));
            if (n > 0) chk("q", 64'(q), 64'(sb[0]));
            if (rd_en && n > 0) void'(sb.pop_front());
            if (wr_en && n < DEPTH) sb.push_back(data);
        end
    end

    task automatic cyc(input logic w, input logic [DSIZE-1:0] d, input logic r);
        wr_en = w;
        data  = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2*DEPTH && !empty; i++) cyc(1'b0, '0, 1'b1);
    endtask

    initial begin
        int written;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // First word after reset falls through on the next cycle.
        cyc(1'b1, 36'h9_ABCD_0123, 1'b0);
        chk("first_q", 64'(q), 64'h9_ABCD_0123);
        chk("first_rnum", 64'(rnum), 1);
        for (int i = 0; i < 6; i++) cyc(1'b1, DSIZE'($urandom), 1'b0);

        // Asynchronous reset mid-run clears state without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        chk("async_rst_empty", 64'(empty), 1);
        chk("async_rst_rnum", 64'(rnum), 0);
        chk("async_rst_full", 64'(full), 0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 36'h9_ABCD_0123, 1'b0);
        chk("post_rst_q", 64'(q), 64'h9_ABCD_0123);
        drain();

        // Fill 0..511 then one dropped write.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DSIZE'(i), 1'b0);
        chk("fill_full", 64'(full), 1);
        cyc(1'b1, 36'hF_FFFF_FFFF, 1'b0);
        chk("overflow_rnum", 64'(rnum), 512);
        chk("overflow_q", 64'(q), 0);

        // Drain in order, then an extra read on empty.
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
        chk("drain_empty", 64'(empty), 1);
        chk("drain_rnum", 64'(rnum), 0);
        cyc(1'b0, '0, 1'b1);
        chk("underflow_rnum", 64'(rnum), 0);

        // Steady read+write at occupancy 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, DSIZE'($urandom), 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b1, {4'($urandom), 32'($urandom)}, 1'b1);
        chk("rw5_rnum", 64'(rnum), 5);
        drain();

        // Both enables at empty: only the write lands.
        cyc(1'b1, 36'h1_2345_6789, 1'b1);
        chk("rw_empty_rnum", 64'(rnum), 1);
        chk("rw_empty_q", 64'(q), 64'h1_2345_6789);

        // Both enables at full: only the read lands.
        while (!full) cyc(1'b1, {4'($urandom), 32'($urandom)}, 1'b0);
        cyc(1'b1, 36'hA_AAAA_AAAA, 1'b1);
        chk("rw_full_rnum", 64'(rnum), 511);
        drain();

        // Random traffic across many pointer wraps.
        written = 0;
        for (int i = 0; i < 20000 && written < 2000; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 55);
            if (w && !full) written++;
            cyc(w, {4'($urandom), 32'($urandom)}, r);
        end
        chk("random_written", 64'(written), 2000);
        drain();
        cyc(1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
